// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Turns one raw mechanical push-button into clean, single-cycle event pulses.
// The raw level is brought into the clk domain by a 2-flop synchronizer. A
// debounce FSM then qualifies presses and releases. One counter is shared
// between the debounce windows and the long-press timer.
//
// Ports
//   clk      in   system clock; all logic runs on the rising edge
//   rst_n    in   asynchronous, active-low reset
//   btn_in   in   raw asynchronous button level (polarity set by ACTIVE_LOW)
//   o_press  out  one-cycle pulse per debounced press
//   o_long   out  one-cycle pulse once a press has been held LONG_PRESS_MS
//   o_held   out  level, high while the FSM is in HELD
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter logic [31:0] CLOCK_FREQ    = 32'd50_000_000,
    parameter logic [31:0] DEBOUNCE_MS   = 32'd20,
    parameter logic [31:0] LONG_PRESS_MS = 32'd1000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic o_press,
    output logic o_long,
    output logic o_held
);

    // Both cycle counts must come out >= 1 for the chosen parameters.
    localparam logic [31:0] DB_CYCLES   = CLOCK_FREQ / 32'd1000 * DEBOUNCE_MS;
    localparam logic [31:0] LONG_CYCLES = CLOCK_FREQ / 32'd1000 * LONG_PRESS_MS;

    // The counter also has to reach DB_CYCLES, so size it for the larger of
    // the two limits. The +1 is done in 33 bits so it cannot wrap.
    localparam logic [31:0] MAX_CYCLES = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
    localparam int          CNT_W      = $clog2({1'b0, MAX_CYCLES} + 33'd1);

    localparam logic [CNT_W-1:0] DB_C      = DB_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LONG_C    = LONG_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LONG_M1_C = LONG_C - CNT_W'(1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // Released level of btn_in. The synchronizer resets to this level so that
    // a button still held when reset is released looks like a fresh press.
    localparam logic RELEASED = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic             sync1, sync2;
    logic             pressed_s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, long_nxt;

    // ------------------------------------------------------------------
    // 2-flop synchronizer
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse sync1/sync2 into one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Normalise the polarity so that 1 always means "pressed".
    assign pressed_s = sync2 ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Debounce FSM: state and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: next state, next count and pulse requests
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        long_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pressed_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = ONE_C;
                end
            end

            PRESS_WAIT: begin
                if (!pressed_s) begin
                    // Bounce: drop back without any pulse.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_C) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end

            HELD: begin
                if (pressed_s) begin
                    // Saturate at LONG_C. Because o_long fires only on the
                    // LONG_C-1 -> LONG_C step, it cannot fire twice.
                    if (cnt != LONG_C) begin
                        cnt_nxt  = cnt + ONE_C;
                        long_nxt = (cnt == LONG_M1_C);
                    end
                end else begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = ONE_C;
                end
            end

            RELEASE_WAIT: begin
                if (pressed_s) begin
                    // Release bounce: resume HELD with the long timer spent,
                    // so neither o_press nor o_long can repeat.
                    state_nxt = HELD;
                    cnt_nxt   = LONG_C;
                end else if (cnt == DB_C) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    // o_held is taken from the next state so that it lines up with the
    // cycles the FSM actually spends in HELD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_press <= 1'b0;
            o_long  <= 1'b0;
            o_held  <= 1'b0;
        end else begin
            o_press <= press_nxt;
            o_long  <= long_nxt;
            o_held  <= (state_nxt == HELD);
        end
    end

endmodule
